// File: rtl/bp_me_pkg.sv
// Shared types for the LCE request path: configuration table, miss/request
// enums, the packed LCE->CCE request header and the credit-count width helper.
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_bp_inv_cfg = 1'b0
    } bp_params_e;

    typedef struct packed {
        int lce_id_width;
        int cce_id_width;
        int paddr_width;
        int lce_assoc;
        int dword_width;
    } bp_cfg_s;

    localparam int inv_lce_id_width_lp = 4;
    localparam int inv_cce_id_width_lp = 4;
    localparam int inv_paddr_width_lp  = 40;
    localparam int inv_lce_assoc_lp    = 8;
    localparam int inv_dword_width_lp  = 64;

    function automatic bp_cfg_s bp_get_cfg(input bp_params_e cfg);
        bp_cfg_s c;
        c.lce_id_width = inv_lce_id_width_lp;
        c.cce_id_width = inv_cce_id_width_lp;
        c.paddr_width  = inv_paddr_width_lp;
        c.lce_assoc    = inv_lce_assoc_lp;
        c.dword_width  = inv_dword_width_lp;
        case (cfg)
            e_bp_inv_cfg: c.lce_assoc = inv_lce_assoc_lp;
            default:      c.lce_assoc = inv_lce_assoc_lp;
        endcase
        return c;
    endfunction

    // Encoding of miss_type_i as presented by the cache.
    typedef enum logic [1:0] {
        e_miss_rd    = 2'd0,
        e_miss_wr    = 2'd1,
        e_miss_uc_rd = 2'd2,
        e_miss_uc_wr = 2'd3
    } bp_lce_miss_type_e;

    typedef enum logic [1:0] {
        e_lce_req_type_rd    = 2'd0,
        e_lce_req_type_wr    = 2'd1,
        e_lce_req_type_uc_rd = 2'd2,
        e_lce_req_type_uc_wr = 2'd3
    } bp_lce_cce_req_type_e;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_send  = 2'd1,
        e_block = 2'd2
    } bp_lce_req_state_e;

    typedef struct packed {
        bp_lce_cce_req_type_e                     msg_type;
        logic [inv_lce_id_width_lp-1:0]           src_id;
        logic [inv_cce_id_width_lp-1:0]           dst_id;
        logic [inv_paddr_width_lp-1:0]            addr;
        logic [$clog2(inv_lce_assoc_lp)-1:0]      lru_way_id;
        logic                                     lru_dirty;
        logic                                     non_exclusive;
        logic [1:0]                               uc_size;
        logic [inv_dword_width_lp-1:0]            data;
    } bp_lce_cce_req_s;

    // Count must represent 0..credits inclusive.
    function automatic int credit_count_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/bp_lce_req_credit_ctr.sv
// Outstanding-request credit counter: saturates at credits_p, holds at zero
// on underflow and raises a sticky error flag that only reset clears.
module bp_lce_req_credit_ctr
    import bp_me_pkg::*;
#(
    parameter  int credits_p = 8,
    localparam int width_lp  = credit_count_width(credits_p)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    output logic [width_lp-1:0] count,
    output logic                empty,
    output logic                avail,
    output logic                err
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(credits_p);
    localparam logic [width_lp-1:0] one_lp = width_lp'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            err   <= 1'b0;
        end else if (inc && !dec) begin
            if (count < max_lp) begin
                count <= count + one_lp;
            end
        end else if (dec && !inc) begin
            if (count == '0) begin
                err <= 1'b1;
            end else begin
                count <= count - one_lp;
            end
        end
    end

    assign empty = (count == '0);
    assign avail = (count < max_lp);

endmodule

// File: rtl/bp_lce_req_gen.sv
// LCE miss-to-request generator: captures a miss, presents one registered
// request header to the CCE and tracks outstanding credits.
// Optional feature macro: BP_LCE_REQ_NONEXCL_EN (non-exclusive read hint).
module bp_lce_req_gen
    import bp_me_pkg::*;
#(
    parameter  bp_params_e bp_params_p    = e_bp_inv_cfg,
    parameter  int credits_p              = 8,
    localparam bp_cfg_s cfg_lp            = bp_get_cfg(bp_params_p),
    localparam int lce_id_width_p         = cfg_lp.lce_id_width,
    localparam int cce_id_width_p         = cfg_lp.cce_id_width,
    localparam int paddr_width_p          = cfg_lp.paddr_width,
    localparam int lce_assoc_p            = cfg_lp.lce_assoc,
    localparam int dword_width_p          = cfg_lp.dword_width,
    localparam int way_width_lp           = $clog2(lce_assoc_p),
    localparam int lce_cce_req_width_lp   = $bits(bp_lce_cce_req_s),
    localparam int count_width_lp         = credit_count_width(credits_p)
)(
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [lce_id_width_p-1:0]       lce_id_i,
    input  logic [cce_id_width_p-1:0]       cce_id_i,

    input  logic                            miss_v_i,
    output logic                            miss_ready_o,
    input  logic [1:0]                      miss_type_i,
    input  logic [paddr_width_p-1:0]        miss_addr_i,
    input  logic [way_width_lp-1:0]         miss_lru_way_i,
    input  logic                            miss_lru_dirty_i,
    input  logic                            miss_non_excl_i,
    input  logic [1:0]                      miss_uc_size_i,
    input  logic [dword_width_p-1:0]        miss_data_i,

    output logic [lce_cce_req_width_lp-1:0] lce_req_o,
    output logic                            lce_req_v_o,
    input  logic                            lce_req_ready_i,

    input  logic                            cmd_done_i,
    input  logic                            credit_return_i,
    output logic                            credits_empty_o,
    output logic                            credit_err_o,

    output bp_lce_req_state_e               fsm_state,
    output logic [count_width_lp-1:0]       credit_count
);

    bp_lce_req_state_e state_r, state_n;
    bp_lce_cce_req_s   req_r, req_n;
    logic              accept, send, blocking, credit_avail;

    // Handshake rule for both ports: a transfer happens in a cycle where
    // valid and ready are both high; valid never drops before that cycle.
    assign accept = miss_v_i & miss_ready_o;
    assign send   = lce_req_v_o & lce_req_ready_i;

    // Cached misses wait for the CCE to finish the fill/upgrade.
    assign blocking = (req_r.msg_type == e_lce_req_type_rd)
                   || (req_r.msg_type == e_lce_req_type_wr);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_ready: if (accept)     state_n = e_send;
            e_send:  if (send)       state_n = blocking ? e_block : e_ready;
            e_block: if (cmd_done_i) state_n = e_ready;
            default:                 state_n = e_ready;
        endcase
    end

    always_comb begin
        miss_ready_o = (state_r == e_ready) && credit_avail;
        lce_req_v_o  = (state_r == e_send);
    end

    always_comb begin
        req_n               = '0;
        req_n.src_id        = lce_id_i;
        req_n.dst_id        = cce_id_i;
        req_n.addr          = miss_addr_i;
        req_n.lru_way_id    = miss_lru_way_i;
        req_n.lru_dirty     = miss_lru_dirty_i;
        req_n.uc_size       = miss_uc_size_i;
        case (bp_lce_miss_type_e'(miss_type_i))
            e_miss_rd:    req_n.msg_type = e_lce_req_type_rd;
            e_miss_wr:    req_n.msg_type = e_lce_req_type_wr;
            e_miss_uc_rd: req_n.msg_type = e_lce_req_type_uc_rd;
            e_miss_uc_wr: req_n.msg_type = e_lce_req_type_uc_wr;
            default:      req_n.msg_type = e_lce_req_type_rd;
        endcase
        if (bp_lce_miss_type_e'(miss_type_i) == e_miss_uc_wr) begin
            req_n.data = miss_data_i;
        end
`ifdef BP_LCE_REQ_NONEXCL_EN
        req_n.non_exclusive = miss_non_excl_i
                           && (bp_lce_miss_type_e'(miss_type_i) == e_miss_rd);
`else
        req_n.non_exclusive = 1'b0;
`endif
    end

`ifndef BP_LCE_REQ_NONEXCL_EN
    logic unused_non_excl;
    assign unused_non_excl = miss_non_excl_i;
`endif

    // Header is frozen at accept so the CCE sees a stable request while stalled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req_r <= '0;
        end else if (accept) begin
            req_r <= req_n;
        end
    end

    assign lce_req_o = req_r;
    assign fsm_state = state_r;

    bp_lce_req_credit_ctr #(
        .credits_p (credits_p)
    ) credit_ctr (
        .clk   (clk_i),
        .reset (reset_i),
        .inc   (send),
        .dec   (credit_return_i),
        .count (credit_count),
        .empty (credits_empty_o),
        .avail (credit_avail),
        .err   (credit_err_o)
    );

endmodule

// File: tb/tb_bp_lce_req_gen.sv
// Bench for bp_lce_req_gen: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the request/credit rules.
module tb_bp_lce_req_gen;
    import bp_me_pkg::*;

    localparam int CRED = 8;
`ifdef BP_LCE_REQ_NONEXCL_EN
    localparam logic NONEXCL_EXP = 1'b1;
`else
    localparam logic NONEXCL_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic [3:0]        lce_id_i = '0;
    logic [3:0]        cce_id_i = '0;
    logic              miss_v_i = 1'b0;
    logic              miss_ready_o;
    logic [1:0]        miss_type_i = '0;
    logic [39:0]       miss_addr_i = '0;
    logic [2:0]        miss_lru_way_i = '0;
    logic              miss_lru_dirty_i = 1'b0;
    logic              miss_non_excl_i = 1'b0;
    logic [1:0]        miss_uc_size_i = '0;
    logic [63:0]       miss_data_i = '0;
    logic [$bits(bp_lce_cce_req_s)-1:0] lce_req_o;
    logic              lce_req_v_o;
    logic              lce_req_ready_i = 1'b0;
    logic              cmd_done_i = 1'b0;
    logic              credit_return_i = 1'b0;
    logic              credits_empty_o;
    logic              credit_err_o;
    bp_lce_req_state_e fsm_state;
    logic [3:0]        credit_count;

    int total = 0;
    int bad = 0;

    // Model: phase 0 = can take a miss, 1 = request on the wire, 2 = waiting on CCE
    int              m_phase = 0;
    int              m_cnt = 0;
    bit              m_err = 1'b0;
    bit              m_blocking = 1'b0;
    bp_lce_cce_req_s m_hdr = '0;
    bp_lce_cce_req_s got_hdr;

    always #5 clk = ~clk;

    bp_lce_req_gen #(.bp_params_p(e_bp_inv_cfg), .credits_p(CRED)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .lce_id_i         (lce_id_i),
        .cce_id_i         (cce_id_i),
        .miss_v_i         (miss_v_i),
        .miss_ready_o     (miss_ready_o),
        .miss_type_i      (miss_type_i),
        .miss_addr_i      (miss_addr_i),
        .miss_lru_way_i   (miss_lru_way_i),
        .miss_lru_dirty_i (miss_lru_dirty_i),
        .miss_non_excl_i  (miss_non_excl_i),
        .miss_uc_size_i   (miss_uc_size_i),
        .miss_data_i      (miss_data_i),
        .lce_req_o        (lce_req_o),
        .lce_req_v_o      (lce_req_v_o),
        .lce_req_ready_i  (lce_req_ready_i),
        .cmd_done_i       (cmd_done_i),
        .credit_return_i  (credit_return_i),
        .credits_empty_o  (credits_empty_o),
        .credit_err_o     (credit_err_o),
        .fsm_state        (fsm_state),
        .credit_count     (credit_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bp_lce_cce_req_s build_hdr();
        bp_lce_cce_req_s h;
        h = '0;
        case (miss_type_i)
            2'd0:    h.msg_type = e_lce_req_type_rd;
            2'd1:    h.msg_type = e_lce_req_type_wr;
            2'd2:    h.msg_type = e_lce_req_type_uc_rd;
            default: h.msg_type = e_lce_req_type_uc_wr;
        endcase
        h.src_id        = lce_id_i;
        h.dst_id        = cce_id_i;
        h.addr          = miss_addr_i;
        h.lru_way_id    = miss_lru_way_i;
        h.lru_dirty     = miss_lru_dirty_i;
        h.uc_size       = miss_uc_size_i;
        h.data          = (miss_type_i == 2'd3) ? miss_data_i : 64'd0;
        h.non_exclusive = NONEXCL_EXP && (miss_type_i == 2'd0) && miss_non_excl_i;
        return h;
    endfunction

    task automatic check_outputs();
        logic [1:0] exp_state;
        case (m_phase)
            0:       exp_state = e_ready;
            1:       exp_state = e_send;
            default: exp_state = e_block;
        endcase
        check("miss_ready", 128'(miss_ready_o), 128'((m_phase == 0) && (m_cnt < CRED)));
        check("req_v", 128'(lce_req_v_o), 128'(m_phase == 1));
        check("req_hdr", 128'(lce_req_o), 128'(m_hdr));
        check("count", 128'(credit_count), 128'(m_cnt));
        check("empty", 128'(credits_empty_o), 128'(m_cnt == 0));
        check("err", 128'(credit_err_o), 128'(m_err));
        check("state", 128'(fsm_state), 128'(exp_state));
    endtask

    // Advance one clock: predict from current inputs, clock, then compare.
    task automatic step();
        bit acc, snd, n_err, n_blk;
        int n_phase, n_cnt;
        bp_lce_cce_req_s n_hdr;
        n_phase = m_phase; n_cnt = m_cnt; n_err = m_err; n_hdr = m_hdr; n_blk = m_blocking;
        acc = (m_phase == 0) && (m_cnt < CRED) && miss_v_i;
        snd = (m_phase == 1) && lce_req_ready_i;
        if (reset_i) begin
            n_phase = 0; n_cnt = 0; n_err = 1'b0; n_hdr = '0; n_blk = 1'b0;
        end else begin
            if (snd && !credit_return_i) n_cnt = m_cnt + 1;
            else if (credit_return_i && !snd) begin
                if (m_cnt == 0) n_err = 1'b1;
                else n_cnt = m_cnt - 1;
            end
            if (acc) begin
                n_phase = 1;
                n_hdr = build_hdr();
                n_blk = (miss_type_i < 2'd2);
            end else if (snd) begin
                n_phase = m_blocking ? 2 : 0;
            end else if (m_phase == 2 && cmd_done_i) begin
                n_phase = 0;
            end
        end
        @(posedge clk);
        m_phase = n_phase; m_cnt = n_cnt; m_err = n_err; m_hdr = n_hdr; m_blocking = n_blk;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_fields();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        lce_id_i         = 4'($urandom_range(0, 15));
        cce_id_i         = 4'($urandom_range(0, 15));
        miss_type_i      = 2'($urandom_range(0, 3));
        miss_addr_i      = r64[39:0];
        miss_lru_way_i   = 3'($urandom_range(0, 7));
        miss_lru_dirty_i = 1'($urandom_range(0, 1));
        miss_non_excl_i  = 1'($urandom_range(0, 1));
        miss_uc_size_i   = 2'($urandom_range(0, 3));
        miss_data_i      = {$urandom(), $urandom()};
    endtask

    task automatic set_miss(input logic [1:0] t, input logic [39:0] a, input logic [63:0] d,
                            input logic [1:0] sz, input logic ne);
        rand_fields();
        miss_v_i        = 1'b1;
        miss_type_i     = t;
        miss_addr_i     = a;
        miss_data_i     = d;
        miss_uc_size_i  = sz;
        miss_non_excl_i = ne;
    endtask

    task automatic idle_inputs();
        miss_v_i = 1'b0; lce_req_ready_i = 1'b0; cmd_done_i = 1'b0; credit_return_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_ready", 128'(miss_ready_o), 128'(1));
        check("rst_v", 128'(lce_req_v_o), 128'(0));
        check("rst_hdr", 128'(lce_req_o), 128'(0));

        // Stalled cached read holds its header, then blocks after handshake.
        set_miss(2'd0, 40'h80_0000_0040, 64'h1234, 2'd0, 1'b0);
        step();
        miss_v_i = 1'b0;
        got_hdr = lce_req_o;
        check("r30_addr", 128'(got_hdr.addr), 128'(40'h80_0000_0040));
        repeat (2) step();
        check("r30_v3", 128'(lce_req_v_o), 128'(1));
        lce_req_ready_i = 1'b1;
        step();
        lce_req_ready_i = 1'b0;
        check("r30_state", 128'(fsm_state), 128'(e_block));
        check("r30_count", 128'(credit_count), 128'(1));
        cmd_done_i = 1'b1;
        step();
        cmd_done_i = 1'b0;
        check("r30_unblock", 128'(fsm_state), 128'(e_ready));

        // Uncached write carries its data word.
        do_reset();
        set_miss(2'd3, 40'h12_3456_7890, 64'hDEAD_BEEF, 2'd3, 1'b0);
        lce_req_ready_i = 1'b1;
        step();
        miss_v_i = 1'b0;
        got_hdr = lce_req_o;
        check("r31_type", 128'(got_hdr.msg_type), 128'(e_lce_req_type_uc_wr));
        check("r31_data", 128'(got_hdr.data), 128'(64'hDEAD_BEEF));
        check("r31_size", 128'(got_hdr.uc_size), 128'(3));
        step();
        check("r31_ready1", 128'(miss_ready_o), 128'(1));
        step();
        check("r31_ready2", 128'(miss_ready_o), 128'(1));

        // Credit exhaustion and recovery.
        do_reset();
        set_miss(2'd2, 40'h0, 64'h0, 2'd1, 1'b0);
        lce_req_ready_i = 1'b1;
        repeat (16) step();
        check("r32_count", 128'(credit_count), 128'(8));
        check("r32_full", 128'(miss_ready_o), 128'(0));
        step();
        check("r32_stays", 128'(miss_ready_o), 128'(0));
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        miss_v_i = 1'b0;
        check("r32_ret", 128'(miss_ready_o), 128'(1));
        check("r32_count7", 128'(credit_count), 128'(7));

        // Send and return in the same cycle cancel out.
        do_reset();
        set_miss(2'd2, 40'h40, 64'h0, 2'd0, 1'b0);
        lce_req_ready_i = 1'b1;
        repeat (7) step();
        miss_v_i = 1'b0;
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        check("r33_count", 128'(credit_count), 128'(3));

        // Underflow is sticky until reset.
        do_reset();
        credit_return_i = 1'b1;
        step();
        credit_return_i = 1'b0;
        check("r34_count", 128'(credit_count), 128'(0));
        check("r34_err", 128'(credit_err_o), 128'(1));
        repeat (3) step();
        check("r34_sticky", 128'(credit_err_o), 128'(1));
        do_reset();
        check("r34_clear", 128'(credit_err_o), 128'(0));

        // Reset drops a pending request; non-exclusive hint depends on build.
        set_miss(2'd2, 40'h80, 64'h0, 2'd0, 1'b0);
        lce_req_ready_i = 1'b1;
        repeat (2) step();
        set_miss(2'd0, 40'h100, 64'h0, 2'd0, 1'b1);
        lce_req_ready_i = 1'b0;
        step();
        miss_v_i = 1'b0;
        got_hdr = lce_req_o;
        check("r35_nonexcl", 128'(got_hdr.non_exclusive), 128'(NONEXCL_EXP));
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("r35_v", 128'(lce_req_v_o), 128'(0));
        check("r35_count", 128'(credit_count), 128'(0));
        step();
        check("r35_dropped", 128'(lce_req_v_o), 128'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            miss_v_i        = 1'($urandom_range(0, 1));
            lce_req_ready_i = ($urandom_range(0, 2) != 0);
            cmd_done_i      = ($urandom_range(0, 3) == 0);
            credit_return_i = ($urandom_range(0, 6) == 0);
            reset_i         = ($urandom_range(0, 199) == 0);
            step();
        end
        reset_i = 1'b0;
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
